book_mem_arbiter: RTL and testbench

- Shares the single order-book memory port between three requesters: 0 = add_order, 1 = cancel_order, 2 = match/search unit.
- Each requester uses the existing one-cycle mem_start pulse protocol.
- The block latches requests, grants them in round-robin order, and runs one memory transaction at a time.
- It routes the completion valid and read data back to the granted requester, with a watchdog timeout.

---
 rtl/book_mem_arbiter.sv | 159 +++++++++++++++
 tb/tb_book_mem_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/book_mem_arbiter.sv
// Round-robin arbiter sharing the single order-book memory port between
// add_order (0), cancel_order (1) and the match/search unit (2).
module book_mem_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                  clk_in,
  input  logic                  rst,
  input  logic [2:0]            req_start,
  input  logic [3*ADDR_W-1:0]   req_addr,
  input  logic [3*DATA_W-1:0]   req_data,
  input  logic [2:0]            req_we,
  output logic [2:0]            req_valid,
  output logic                  req_err,
  output logic [DATA_W-1:0]     rd_data,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_data_w,
  output logic                  mem_is_write,
  output logic                  mem_start,
  input  logic                  mem_valid,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  busy,
  output logic [2:0]            overflow
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t              state;
  logic [1:0]          last_grant;
  logic [1:0]          grant_next;
  logic [CNT_W-1:0]    cnt;
  logic [2:0]          pending;
  logic [2:0]          done_clr;
  logic                done;
  logic [ADDR_W-1:0]   slot_addr [3];
  logic [DATA_W-1:0]   slot_data [3];
  logic                slot_we   [3];

  function automatic logic [1:0] next_idx(input logic [1:0] x);
    next_idx = (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  // First pending index after the previous grant; falls back to the
  // previous grant itself when it is the only one pending.
  function automatic logic [1:0] pick_grant(input logic [2:0] pend,
                                            input logic [1:0] last);
    logic [1:0] c1;
    logic [1:0] c2;
    c1 = next_idx(last);
    c2 = next_idx(c1);
    if (pend[c1])
      pick_grant = c1;
    else if (pend[c2])
      pick_grant = c2;
    else
      pick_grant = last;
  endfunction

  function automatic logic [2:0] grant_onehot(input logic [1:0] g);
    grant_onehot = 3'b001 << g;
  endfunction

  assign grant_next = pick_grant(pending, last_grant);
  assign done       = (state == S_WAIT) &&
                      (mem_valid || (cnt == CNT_W'(TIMEOUT - 1)));
  assign done_clr   = done ? grant_onehot(last_grant) : 3'b000;

  // Request capture: a new start in the completion cycle re-arms the slot.
  for (genvar gi = 0; gi < 3; gi++) begin : g_slot
    logic              p_q;
    logic              ov_q;
    logic [ADDR_W-1:0] a_q;
    logic [DATA_W-1:0] d_q;
    logic              we_q;

    always_ff @(posedge clk_in) begin
      if (rst) begin
        p_q  <= 1'b0;
        ov_q <= 1'b0;
        a_q  <= '0;
        d_q  <= '0;
        we_q <= 1'b0;
      end else if (req_start[gi]) begin
        if (!p_q || done_clr[gi]) begin
          p_q  <= 1'b1;
          a_q  <= req_addr[gi*ADDR_W +: ADDR_W];
          d_q  <= req_data[gi*DATA_W +: DATA_W];
          we_q <= req_we[gi];
        end else begin
          ov_q <= 1'b1;
        end
      end else if (done_clr[gi]) begin
        p_q <= 1'b0;
      end
    end

    assign pending[gi]   = p_q;
    assign overflow[gi]  = ov_q;
    assign slot_addr[gi] = a_q;
    assign slot_data[gi] = d_q;
    assign slot_we[gi]   = we_q;
  end

  // Transaction FSM: last_grant doubles as the in-flight requester index.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state        <= S_IDLE;
      last_grant   <= 2'd2;
      cnt          <= '0;
      mem_addr     <= '0;
      mem_data_w   <= '0;
      mem_is_write <= 1'b0;
      mem_start    <= 1'b0;
      req_valid    <= 3'b000;
      req_err      <= 1'b0;
      rd_data      <= '0;
      busy         <= 1'b0;
    end else begin
      mem_start <= 1'b0;
      req_valid <= 3'b000;
      req_err   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (|pending) begin
            last_grant   <= grant_next;
            mem_addr     <= slot_addr[grant_next];
            mem_data_w   <= slot_data[grant_next];
            mem_is_write <= slot_we[grant_next];
            mem_start    <= 1'b1;
            busy         <= 1'b1;
            cnt          <= '0;
            state        <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_valid) begin
            rd_data   <= mem_rdata;
            req_valid <= grant_onehot(last_grant);
            busy      <= 1'b0;
            state     <= S_IDLE;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            rd_data   <= '0;
            req_valid <= grant_onehot(last_grant);
            req_err   <= 1'b1;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_book_mem_arbiter.sv
// Scoreboard bench: a transaction-level model predicts memory issues and
// completions from the inputs alone; a negedge monitor compares the DUT.
module tb_book_mem_arbiter;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int TO = 16;
  localparam int M_RAND  = 0;
  localparam int M_DELAY = 1;
  localparam int M_NEVER = 2;

  logic              clk_in = 1'b0;
  logic              rst;
  logic [2:0]        req_start;
  logic [3*AW-1:0]   req_addr;
  logic [3*DW-1:0]   req_data;
  logic [2:0]        req_we;
  logic [2:0]        req_valid;
  logic              req_err;
  logic [DW-1:0]     rd_data;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_data_w;
  logic              mem_is_write;
  logic              mem_start;
  logic              mem_valid = 1'b0;
  logic [DW-1:0]     mem_rdata = '0;
  logic              busy;
  logic [2:0]        overflow;

  book_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk_in(clk_in), .rst(rst), .req_start(req_start), .req_addr(req_addr),
    .req_data(req_data), .req_we(req_we), .req_valid(req_valid),
    .req_err(req_err), .rd_data(rd_data), .mem_addr(mem_addr),
    .mem_data_w(mem_data_w), .mem_is_write(mem_is_write),
    .mem_start(mem_start), .mem_valid(mem_valid), .mem_rdata(mem_rdata),
    .busy(busy), .overflow(overflow)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; logic we; } mem_t;
  typedef struct packed { logic [2:0] v; logic e; logic [DW-1:0] d; } cmp_t;

  mem_t exp_mem[$];
  cmp_t exp_cmp[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_err = 0;

  // memory responder controls
  int          mode  = M_DELAY;
  int          dly   = 3;
  int          vrate = 4;
  int          cd    = 0;
  logic [DW-1:0] rval = '0;

  // reference model state
  bit [2:0]    m_pend   = 3'b000;
  bit [2:0]    m_ovf    = 3'b000;
  bit          m_active = 1'b0;
  bit          m_rst    = 1'b0;
  int          m_last   = 2;
  int          m_k      = 0;
  logic [AW-1:0] s_addr [3];
  logic [DW-1:0] s_data [3];
  logic          s_we   [3];

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  // Model: one pass per clock edge using only the bench-driven inputs.
  always @(posedge clk_in) begin
    int  g;
    bit  found;
    if (rst) begin
      m_pend = 3'b000; m_ovf = 3'b000; m_active = 1'b0; m_last = 2; m_k = 0; m_rst = 1'b1;
    end else begin
      m_rst = 1'b0;
      if (!m_active) begin
        if (m_pend != 3'b000) begin
          found = 1'b0;
          g = m_last;
          for (int s = 1; s <= 3; s++)
            if (!found && m_pend[(m_last + s) % 3]) begin
              g = (m_last + s) % 3;
              found = 1'b1;
            end
          m_last = g;
          m_active = 1'b1;
          m_k = 0;
          exp_mem.push_back('{s_addr[g], s_data[g], s_we[g]});
        end
      end else begin
        m_k++;
        if (mem_valid || m_k == TO) begin
          exp_cmp.push_back('{3'(1 << m_last), !mem_valid, mem_valid ? mem_rdata : '0});
          m_active = 1'b0;
          m_pend[m_last] = 1'b0;
        end
      end
      for (int i = 0; i < 3; i++)
        if (req_start[i]) begin
          if (m_pend[i]) m_ovf[i] = 1'b1;
          else begin
            m_pend[i] = 1'b1;
            s_addr[i] = req_addr[i*AW +: AW];
            s_data[i] = req_data[i*DW +: DW];
            s_we[i]   = req_we[i];
          end
        end
    end
  end

  // Monitor
  always @(negedge clk_in) begin
    mem_t em;
    cmp_t ec;
    if (m_rst) begin
      check("reset_ctrl", 128'({req_valid, req_err, mem_is_write, mem_start, busy, overflow}), 128'(0));
      check("reset_data", 128'({rd_data, mem_addr, mem_data_w}), 128'(0));
    end else begin
      if (mem_start || exp_mem.size() != 0) begin
        if (exp_mem.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_mem_start: got addr %0h, required no issue", mem_addr);
        end else begin
          em = exp_mem.pop_front();
          check("mem_start", 128'(mem_start), 128'(1));
          check("mem_addr", 128'(mem_addr), 128'(em.a));
          check("mem_data_w", 128'(mem_data_w), 128'(em.d));
          check("mem_is_write", 128'(mem_is_write), 128'(em.we));
        end
      end
      if (req_valid != 3'b000 || exp_cmp.size() != 0) begin
        if (req_valid != 3'b000 && req_err) n_err++;
        if (exp_cmp.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_req_valid: got %b required 000", req_valid);
        end else begin
          ec = exp_cmp.pop_front();
          check("req_valid", 128'(req_valid), 128'(ec.v));
          check("req_err", 128'(req_err), 128'(ec.e));
          check("rd_data", 128'(rd_data), 128'(ec.d));
        end
      end
      check("busy", 128'(busy), 128'(m_active));
      check("overflow", 128'(overflow), 128'(m_ovf));
    end
  end

  // Memory responder
  always @(negedge clk_in) begin
    mem_valid = 1'b0;
    if (mode == M_RAND) begin
      mem_valid = ($urandom_range(0, vrate - 1) == 0);
      mem_rdata = $urandom;
    end else if (mem_start) begin
      cd = dly;
    end else if (cd > 0) begin
      cd--;
      if (cd == 0 && mode == M_DELAY) begin
        mem_valid = 1'b1;
        mem_rdata = rval;
      end
    end
  end

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic we);
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
    req_we[i] = we;
  endtask

  task automatic fire(input logic [2:0] mask);
    req_start = mask;
    @(negedge clk_in);
    req_start = 3'b000;
  endtask

  initial begin
    rst = 1'b1; req_start = 3'b000; req_addr = '0; req_data = '0; req_we = 3'b000;
    repeat (3) @(negedge clk_in);
    check("reset_busy", 128'(busy), 128'(0));
    rst = 1'b0;
    @(negedge clk_in);

    // single write, memory answers 3 cycles after mem_start
    dly = 3; rval = 32'hCAFE0001;
    set_req(0, 8'h05, 32'hDEADBEEF, 1'b1);
    fire(3'b001);
    repeat (8) @(negedge clk_in);

    // round robin over all three, then requester 2 ahead of 0
    dly = 2; rval = 32'h0000AAAA;
    set_req(0, 8'h10, 32'h1, 1'b1);
    set_req(1, 8'h20, 32'h2, 1'b0);
    set_req(2, 8'h30, 32'h3, 1'b1);
    fire(3'b111);
    repeat (15) @(negedge clk_in);
    set_req(0, 8'h11, 32'h4, 1'b0);
    fire(3'b001);
    repeat (6) @(negedge clk_in);
    set_req(0, 8'h12, 32'h5, 1'b1);
    set_req(2, 8'h32, 32'h6, 1'b0);
    fire(3'b101);
    repeat (12) @(negedge clk_in);

    // read data return
    rval = 32'h12345678;
    set_req(1, 8'h07, 32'h0, 1'b0);
    fire(3'b010);
    repeat (6) @(negedge clk_in);

    // timeout, then a normal request afterwards
    mode = M_NEVER;
    set_req(2, 8'h44, 32'h77, 1'b0);
    fire(3'b100);
    repeat (20) @(negedge clk_in);
    check("timeout_seen", 128'(n_err), 128'(1));
    mode = M_DELAY; dly = 2; rval = 32'h55;
    set_req(0, 8'h45, 32'h88, 1'b1);
    fire(3'b001);
    repeat (6) @(negedge clk_in);

    // overflow on requester 1 while in WAIT, then reset mid-transaction
    dly = 10;
    set_req(1, 8'h50, 32'h99, 1'b1);
    fire(3'b010);
    repeat (2) @(negedge clk_in);
    fire(3'b010);
    fire(3'b010);
    check("overflow_req1", 128'(overflow), 128'(3'b010));
    rst = 1'b1;
    @(negedge clk_in);
    check("reset_overflow", 128'(overflow), 128'(0));
    rst = 1'b0;
    repeat (12) @(negedge clk_in);

    // randomized traffic, frequent then sparse memory completions
    mode = M_RAND;
    for (int ph = 0; ph < 2; ph++) begin
      vrate = (ph == 0) ? 4 : 30;
      for (int c = 0; c < 2500; c++) begin
        for (int i = 0; i < 3; i++) begin
          req_start[i] = ($urandom_range(0, 4) == 0);
          if (req_start[i]) set_req(i, AW'($urandom), $urandom, 1'($urandom));
        end
        rst = ($urandom_range(0, 599) == 0);
        @(negedge clk_in);
      end
      req_start = 3'b000;
      rst = 1'b0;
    end

    // drain
    vrate = 2;
    for (int c = 0; c < 300 && (busy || m_pend != 3'b000); c++) @(negedge clk_in);
    check("drain_busy", 128'(busy), 128'(0));
    repeat (3) @(negedge clk_in);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
